monster_fleet_controller: RTL
=============================

# monster_fleet_controller

Sequences the monster formation for one level: loads the fleet, marches it on a frame-tick schedule, descends at screen edges, applies bullet hits to the alive mask and schedules monster shots. Sits between the top-level game state machine (which drives `level` and consumes `win`/`invaded`) and the pixel/collision datapath (which draws from `fleet_x`, `fleet_y`, `alive` and reports hits). Formation is fixed at 3 rows × 8 columns; cell index = row*8 + col.

## Interface
- `STEP_TICKS_L1`, 30: frames per march step in level 1.
- `STEP_TICKS_L2`, 15: frames per march step in level 2.
- `SHOT_TICKS`, 45: frames between shot attempts.
- `X_START`, 160: fleet left-edge x at load.
- `Y_START`, 80: fleet top y at load.
- `X_MIN`, 144: minimum fleet left-edge x.
- `X_MAX`, 400: maximum fleet left-edge x.
- `STEP_X`, 8: horizontal step in pixels.
- `STEP_Y`, 16: descent step in pixels.
- `Y_LIMIT`, 360: fleet_y at or beyond this means invasion.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `level` in 3: 0 = idle, 1/2 = active level; other values are treated as 2.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `hit_valid` in 1: one-cycle hit report from the collision logic.
- `hit_row` in 2: row of the hit cell.
- `hit_col` in 3: column of the hit cell.
- `shot_ack` in 1: bullet datapath accepted the shot.
- `fleet_x` out 10: fleet left-edge x.
- `fleet_y` out 10: fleet top y.
- `alive` out 24: alive mask.
- `kill_pulse` out 1: one cycle per accepted kill.
- `win` out 1: all monsters dead.
- `invaded` out 1: fleet reached `Y_LIMIT`.
- `shot_req` out 1: shot request.
- `shot_row` out 2: row of the shooting cell.
- `shot_col` out 3: column of the shooting cell.

## Operation
States: IDLE, LOAD, MARCH, DESCEND, CLEARED, INVADED.
- `level_q` registers `level` every cycle.
- Any change of `level` (level != level_q) forces the next state to LOAD if the new level is nonzero, and to IDLE if it is 0. This overrides every state.
- **IDLE:**
  - `alive`=0 and all flags low.
  - Holds until a level change.
- **LOAD** (1 cycle):
  - Sets `alive`=24'hFFFFFF, `fleet_x`=X_START, `fleet_y`=Y_START, dir=right.
  - Clears the step and shot counters.
  - period = STEP_TICKS_L1 if level==1, else STEP_TICKS_L2.
  - Next state: MARCH.
- **MARCH:**
  - Each `frame_tick` increments `step_cnt`.
  - At `step_cnt`==period-1, `step_cnt` clears and the fleet steps.
  - Stepping right: if fleet_x+STEP_X > X_MAX, go to DESCEND; otherwise fleet_x += STEP_X.
  - Stepping left: if fleet_x < X_MIN+STEP_X, go to DESCEND; otherwise fleet_x -= STEP_X.
- **DESCEND** (1 cycle):
  - fleet_y += STEP_Y and dir flips; `fleet_x` is unchanged.
  - If the new fleet_y ≥ Y_LIMIT, go to INVADED; otherwise go to MARCH.
- **Hits** (accepted only in MARCH or DESCEND):
  - If `hit_valid` and the addressed bit is 1, clear the bit and pulse `kill_pulse`.
  - A hit on a dead cell, or on an index ≥24 (row 3), is ignored.
- **Clear:** when `alive` becomes 0, the next state is CLEARED. This has priority over DESCEND→INVADED in the same cycle.
- **CLEARED:** `win`=1, held until a level change.
- **INVADED:** `invaded`=1, held until a level change. `alive` is frozen.
- **Shot scheduling:**
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every cycle.
  - In MARCH, `shot_cnt` counts frame_ticks. At SHOT_TICKS-1 it clears, and if `shot_req` is low, a shot is requested:
    - start column c = lfsr[2:0];
    - pick the first column from c upward, wrapping, that has any alive cell;
    - `shot_col` = that column, `shot_row` = its highest-numbered alive row;
    - `shot_req`=1.
  - `shot_req`, `shot_row` and `shot_col` hold until `shot_ack`, which clears `shot_req` on the next edge.
  - Leaving MARCH/DESCEND clears `shot_req`.
  - A kill of the requesting cell does not retract the request.

## Timing
- **Reset values:**
  - state IDLE; `fleet_x`=X_START, `fleet_y`=Y_START; dir right.
  - `alive`=0; `kill_pulse`, `win`, `invaded`, `shot_req` = 0; `shot_row`, `shot_col` = 0.
  - LFSR=8'hA5; counters 0; `level_q`=0.
- `rst` asserted mid-level returns to IDLE immediately.
- **Latencies:**
  - Level change → LOAD 1 cycle later; outputs loaded at the following edge.
  - Final step tick → `fleet_x` updates at the next edge.
  - `hit_valid` → `alive`/`kill_pulse` at the next edge; `kill_pulse` is exactly 1 cycle.
  - Last kill → `win` 1 cycle after `alive`==0.
- All outputs are registered. Arithmetic is 10-bit unsigned; the left-bound test is written to avoid underflow.

## Test plan
1. **Load and first step.** Reset, then set level=1. Required: `alive`=FFFFFF, (160,80) after LOAD; after 30 frame_ticks, `fleet_x`=168.
2. **Edge descent.** March until `fleet_x`=400, then one more step. Required: `fleet_y`=96, `fleet_x`=400, dir left; the next step gives `fleet_x`=392.
3. **Hit handling.** Hit row1/col3. Required: bit 11 clears and `kill_pulse` is high for one cycle. Repeat the same hit → no pulse. A hit with row=3 → no change.
4. **Win vs. invasion.** Kill all 24 cells. Required: `win`=1 and held. Variant: make the last kill coincide with a DESCEND that reaches `Y_LIMIT` → CLEARED, `invaded`=0.
5. **Shot handshake.** Run 45 frames. Required: `shot_req`=1 with `shot_row`=2 for a full column; no ack for 100 frames → row/col are stable and no re-request occurs. Assert `shot_ack` → `shot_req` is 0 next cycle. With column lfsr[2:0] fully dead, the next alive column is chosen.
6. **Level switch and reset.** Switch level 1→2 mid-march. Required: reload to (160,80) and step every 15 frames. Async `rst` mid-level → IDLE, `alive`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/monster_fleet_controller.sv
// Monster formation sequencer: loads a 3x8 fleet, marches it on frame ticks,
// descends at screen edges, applies hits to the alive mask and schedules shots.
module monster_fleet_controller #(
  parameter logic [7:0] STEP_TICKS_L1 = 8'd30,
  parameter logic [7:0] STEP_TICKS_L2 = 8'd15,
  parameter logic [7:0] SHOT_TICKS    = 8'd45,
  parameter logic [9:0] X_START       = 10'd160,
  parameter logic [9:0] Y_START       = 10'd80,
  parameter logic [9:0] X_MIN         = 10'd144,
  parameter logic [9:0] X_MAX         = 10'd400,
  parameter logic [9:0] STEP_X        = 10'd8,
  parameter logic [9:0] STEP_Y        = 10'd16,
  parameter logic [9:0] Y_LIMIT       = 10'd360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  level,
  input  logic        frame_tick,
  input  logic        hit_valid,
  input  logic [1:0]  hit_row,
  input  logic [2:0]  hit_col,
  input  logic        shot_ack,
  output logic [9:0]  fleet_x,
  output logic [9:0]  fleet_y,
  output logic [23:0] alive,
  output logic        kill_pulse,
  output logic        win,
  output logic        invaded,
  output logic        shot_req,
  output logic [1:0]  shot_row,
  output logic [2:0]  shot_col
);

  typedef enum logic [2:0] {IDLE, LOAD, MARCH, DESCEND, CLEARED, INVADED} state_t;

  state_t      state, state_n;
  logic [2:0]  level_q;
  logic        dir, dir_n;
  logic [9:0]  x_n, y_n;
  logic [23:0] alive_n;
  logic        kill_n;
  logic [7:0]  step_cnt, step_n, shot_cnt, shot_n, period, period_n, lfsr;
  logic        req_n;
  logic [1:0]  row_n;
  logic [2:0]  col_n;
  logic [4:0]  hit_idx;
  logic [7:0]  col_alive;
  logic        pick_ok;
  logic [2:0]  pick_col;
  logic [1:0]  pick_row;
  logic        active;

  assign hit_idx = {hit_row, 3'b000} + {2'b00, hit_col};
  assign active  = (state == MARCH) || (state == DESCEND);

  // Shooter choice: first column at or after lfsr[2:0] (wrapping) with a live
  // cell, firing from its lowest-on-screen (highest-numbered) live row.
  always_comb begin : pick
    logic [2:0] cand;
    cand = 3'd0;
    for (int c = 0; c < 8; c++)
      col_alive[c] = alive[c] | alive[c + 8] | alive[c + 16];
    pick_ok  = 1'b0;
    pick_col = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = lfsr[2:0] + 3'(k);
      if (col_alive[cand]) begin
        pick_ok  = 1'b1;
        pick_col = cand;
      end
    end
    if (alive[{2'b10, pick_col}])      pick_row = 2'd2;
    else if (alive[{2'b01, pick_col}]) pick_row = 2'd1;
    else                               pick_row = 2'd0;
  end

  always_comb begin
    state_n  = state;
    x_n      = fleet_x;
    y_n      = fleet_y;
    dir_n    = dir;
    alive_n  = alive;
    kill_n   = 1'b0;
    step_n   = step_cnt;
    shot_n   = shot_cnt;
    period_n = period;
    req_n    = shot_req;
    row_n    = shot_row;
    col_n    = shot_col;

    if (active && hit_valid && hit_row != 2'd3 && alive[hit_idx]) begin
      alive_n[hit_idx] = 1'b0;
      kill_n           = 1'b1;
    end
    if (shot_req && shot_ack) req_n = 1'b0;

    case (state)
      LOAD: begin
        alive_n  = 24'hFFFFFF;
        x_n      = X_START;
        y_n      = Y_START;
        dir_n    = 1'b0;
        step_n   = 8'd0;
        shot_n   = 8'd0;
        period_n = (level_q == 3'd1) ? STEP_TICKS_L1 : STEP_TICKS_L2;
        state_n  = MARCH;
      end
      MARCH: if (frame_tick) begin
        if (step_cnt == period - 8'd1) begin
          step_n = 8'd0;
          // dir 0 = right; the left test is arranged to avoid underflow
          if (!dir) begin
            if (fleet_x + STEP_X > X_MAX) state_n = DESCEND;
            else                          x_n = fleet_x + STEP_X;
          end else begin
            if (fleet_x < X_MIN + STEP_X) state_n = DESCEND;
            else                          x_n = fleet_x - STEP_X;
          end
        end else begin
          step_n = step_cnt + 8'd1;
        end
        if (shot_cnt == SHOT_TICKS - 8'd1) begin
          shot_n = 8'd0;
          if (!shot_req && pick_ok) begin
            req_n = 1'b1;
            row_n = pick_row;
            col_n = pick_col;
          end
        end else begin
          shot_n = shot_cnt + 8'd1;
        end
      end
      DESCEND: begin
        y_n     = fleet_y + STEP_Y;
        dir_n   = ~dir;
        state_n = (y_n >= Y_LIMIT) ? INVADED : MARCH;
      end
      default: ;
    endcase

    // Clearing the fleet beats invasion; a level change beats everything.
    if (active && alive_n == 24'd0) state_n = CLEARED;
    if (level != level_q) begin
      state_n = (level == 3'd0) ? IDLE : LOAD;
      if (level == 3'd0) alive_n = 24'd0;
    end
    if (state_n != MARCH && state_n != DESCEND) req_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      level_q    <= 3'd0;
      fleet_x    <= X_START;
      fleet_y    <= Y_START;
      dir        <= 1'b0;
      alive      <= 24'd0;
      kill_pulse <= 1'b0;
      win        <= 1'b0;
      invaded    <= 1'b0;
      shot_req   <= 1'b0;
      shot_row   <= 2'd0;
      shot_col   <= 3'd0;
      step_cnt   <= 8'd0;
      shot_cnt   <= 8'd0;
      period     <= STEP_TICKS_L1;
      lfsr       <= 8'hA5;
    end else begin
      state      <= state_n;
      level_q    <= level;
      fleet_x    <= x_n;
      fleet_y    <= y_n;
      dir        <= dir_n;
      alive      <= alive_n;
      kill_pulse <= kill_n;
      win        <= (state == CLEARED);
      invaded    <= (state == INVADED);
      shot_req   <= req_n;
      shot_row   <= row_n;
      shot_col   <= col_n;
      step_cnt   <= step_n;
      shot_cnt   <= shot_n;
      period     <= period_n;
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

endmodule
